copcrc_engine: RTL and testbench

- Bit-serial CRC-16 coprocessor that sits directly downstream of the MMI com bridge.
- It consumes the bridge's register-mapped CRC control and data bytes (COPCRCEN, COPCRCINIT1/2, COPCRCI1/2).
- It returns the result bytes and status (COPCRCO1, COPCRCO2, COPCRCSTAT) for readback over the MMI bus.
- Control bytes are level-held by the bridge, so the engine acts only on rising edges of its control bits.

---
 rtl/copcrc_engine.sv | 112 +++++++++++
 tb/tb_copcrc_engine.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/copcrc_engine.sv
// Bit-serial CRC-16 coprocessor behind the MMI com bridge: one data bit per cycle, MSB first.
// Latency: a 1-byte run completes 8 edges after the GO edge; a 2-byte run completes 16 edges after it.
module copcrc_engine #(
   parameter logic [15:0] POLY     = 16'h1021,
   parameter logic [15:0] RST_SEED = 16'hFFFF,
   parameter logic [15:0] XOROUT   = 16'h0000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] COPCRCEN_i,
   input  logic [7:0] COPCRCINIT1_i,
   input  logic [7:0] COPCRCINIT2_i,
   input  logic [7:0] COPCRCI1_i,
   input  logic [7:0] COPCRCI2_i,
   output logic [7:0] COPCRCO1_o,
   output logic [7:0] COPCRCO2_o,
   output logic [7:0] COPCRCSTAT_o
);

   typedef enum logic [1:0] {IDLE, SHIFT1, SHIFT2} state_t;

   state_t      state;
   logic [15:0] crc;
   logic [15:0] result;
   logic [15:0] crc_step;
   logic [7:0]  sh;
   logic [2:0]  bitcnt;
   logic        lenflag;
   logic        go_q;
   logic        init_q;
   logic        busy;
   logic        done;
   logic        err;
   logic        seeded;
   logic        go_rise;
   logic        init_rise;
   logic        fb;
   logic        unused_en;

   assign unused_en = ^COPCRCEN_i[7:3];

   always_comb begin
      go_rise   = COPCRCEN_i[0] & ~go_q;
      init_rise = COPCRCEN_i[1] & ~init_q;
      fb        = crc[15] ^ sh[7];
      crc_step  = {crc[14:0], 1'b0} ^ (fb ? POLY : 16'h0000);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= IDLE;
         crc     <= RST_SEED;
         result  <= 16'h0000;
         sh      <= 8'h00;
         bitcnt  <= 3'd0;
         lenflag <= 1'b0;
         go_q    <= 1'b0;
         init_q  <= 1'b0;
         busy    <= 1'b0;
         done    <= 1'b0;
         err     <= 1'b0;
         seeded  <= 1'b0;
      end else begin
         go_q   <= COPCRCEN_i[0];
         init_q <= COPCRCEN_i[1];
         case (state)
            IDLE: begin
               // A simultaneous INIT is applied first so the run starts from the new seed.
               if (init_rise) begin
                  crc    <= {COPCRCINIT1_i, COPCRCINIT2_i};
                  seeded <= 1'b1;
                  err    <= 1'b0;
               end
               if (go_rise) begin
                  sh      <= COPCRCI1_i;
                  lenflag <= COPCRCEN_i[2];
                  bitcnt  <= 3'd0;
                  busy    <= 1'b1;
                  done    <= 1'b0;
                  state   <= SHIFT1;
               end
            end
            SHIFT1, SHIFT2: begin
               if (go_rise || init_rise) begin
                  err <= 1'b1;
               end
               crc    <= crc_step;
               sh     <= {sh[6:0], 1'b0};
               bitcnt <= bitcnt + 3'd1;
               if (bitcnt == 3'd7) begin
                  if (state == SHIFT1 && lenflag) begin
                     sh     <= COPCRCI2_i;
                     bitcnt <= 3'd0;
                     state  <= SHIFT2;
                  end else begin
                     result <= crc_step;
                     busy   <= 1'b0;
                     done   <= 1'b1;
                     state  <= IDLE;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign COPCRCO1_o   = result[15:8] ^ XOROUT[15:8];
   assign COPCRCO2_o   = result[7:0] ^ XOROUT[7:0];
   assign COPCRCSTAT_o = {4'b0000, seeded, err, done, busy};

endmodule

// File: tb/tb_copcrc_engine.sv
// Directed bench for copcrc_engine: CRC-16/CCITT-FALSE vectors, chaining, error flags and mid-run reset.
module tb_copcrc_engine;

   logic       clk;
   logic       rst;
   logic [7:0] en;
   logic [7:0] init1;
   logic [7:0] init2;
   logic [7:0] i1;
   logic [7:0] i2;
   logic [7:0] co1;
   logic [7:0] co2;
   logic [7:0] stat;

   int total = 0;
   int bad   = 0;

   copcrc_engine dut (
      .clk           (clk),
      .rst           (rst),
      .COPCRCEN_i    (en),
      .COPCRCINIT1_i (init1),
      .COPCRCINIT2_i (init2),
      .COPCRCI1_i    (i1),
      .COPCRCI2_i    (i2),
      .COPCRCO1_o    (co1),
      .COPCRCO2_o    (co2),
      .COPCRCSTAT_o  (stat)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick(input int n);
      for (int k = 0; k < n; k++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check_res(input string tag, input logic [15:0] exp);
      check8({tag, "_co1"}, co1, exp[15:8]);
      check8({tag, "_co2"}, co2, exp[7:0]);
   endtask

   task automatic seed(input logic [7:0] hi, input logic [7:0] lo);
      init1 = hi;
      init2 = lo;
      en[1] = 1'b1;
      tick(1);
      en[1] = 1'b0;
      tick(1);
   endtask

   // GO edge plus the full run length; leaves the bench just after the completing edge.
   task automatic run(input logic [7:0] d1, input logic [7:0] d2, input logic len2);
      i1    = d1;
      i2    = d2;
      en[2] = len2;
      en[0] = 1'b1;
      tick(1);
      en[0] = 1'b0;
      tick(len2 ? 16 : 8);
   endtask

   initial begin
      rst   = 1'b0;
      en    = 8'h00;
      init1 = 8'h00;
      init2 = 8'h00;
      i1    = 8'h00;
      i2    = 8'h00;
      tick(3);
      check8("rst_stat", stat, 8'h00);
      check_res("rst", 16'h0000);
      rst = 1'b1;
      tick(1);

      // 1: out of reset, then seed
      check8("t1_stat", stat, 8'h00);
      check_res("t1", 16'h0000);
      seed(8'hFF, 8'hFF);
      check8("t1_seeded", stat, 8'h08);

      // 2: single byte "1"
      i1    = 8'h31;
      en[2] = 1'b0;
      en[0] = 1'b1;
      tick(1);
      en[0] = 1'b0;
      check8("t2_busy_n", stat, 8'h09);
      for (int k = 1; k < 8; k++) begin
         tick(1);
         check8("t2_busy", stat, 8'h09);
      end
      check_res("t2_hidden", 16'h0000);
      tick(1);
      check8("t2_done", stat, 8'h0A);
      check_res("t2", 16'hC782);

      // 3: two bytes "12", I2 changed after it has been sampled
      seed(8'hFF, 8'hFF);
      check8("t3_seed_stat", stat, 8'h0A);
      i1    = 8'h31;
      i2    = 8'h32;
      en[2] = 1'b1;
      en[0] = 1'b1;
      tick(1);
      en[0] = 1'b0;
      en[2] = 1'b0;
      tick(8);
      i2 = 8'hAA;
      i1 = 8'h55;
      tick(7);
      check8("t3_busy", stat, 8'h09);
      check_res("t3_hidden", 16'hC782);
      tick(1);
      check8("t3_done", stat, 8'h0A);
      check_res("t3", 16'h3DBA);

      // 4: chained "123456789"
      seed(8'hFF, 8'hFF);
      run(8'h31, 8'h32, 1'b1);
      check_res("t4_12", 16'h3DBA);
      run(8'h33, 8'h34, 1'b1);
      run(8'h35, 8'h36, 1'b1);
      run(8'h37, 8'h38, 1'b1);
      run(8'h39, 8'h00, 1'b0);
      check_res("t4", 16'h29B1);
      check8("t4_stat", stat, 8'h0A);

      // 5: GO and INIT rises while busy
      seed(8'hFF, 8'hFF);
      i1    = 8'h31;
      en[2] = 1'b0;
      en[0] = 1'b1;
      tick(1);
      en[0] = 1'b0;
      tick(1);
      init1 = 8'h00;
      init2 = 8'h00;
      en[0] = 1'b1;
      en[1] = 1'b1;
      tick(1);
      en[0] = 1'b0;
      en[1] = 1'b0;
      check8("t5_err", stat, 8'h0D);
      tick(5);
      check8("t5_err_busy", stat, 8'h0D);
      tick(1);
      check8("t5_done", stat, 8'h0E);
      check_res("t5", 16'hC782);
      seed(8'hFF, 8'hFF);
      check8("t5_errclr", stat, 8'h0A);

      // 6: INIT and GO together override crc=0x1234
      seed(8'h12, 8'h34);
      init1 = 8'hFF;
      init2 = 8'hFF;
      i1    = 8'h31;
      en[2] = 1'b0;
      en    = 8'h03;
      tick(1);
      en = 8'h00;
      check8("t6_busy", stat, 8'h09);
      tick(8);
      check_res("t6", 16'hC782);
      check8("t6_done", stat, 8'h0A);

      // 6b: reset mid-run, then crc must restart from 0xFFFF
      en[0] = 1'b1;
      tick(1);
      en[0] = 1'b0;
      tick(4);
      rst = 1'b0;
      #1;
      check8("t6_rst_stat", stat, 8'h00);
      check_res("t6_rst", 16'h0000);
      tick(2);
      rst = 1'b1;
      tick(1);
      run(8'h31, 8'h00, 1'b0);
      check_res("t6_reseed", 16'hC782);
      check8("t6_post_stat", stat, 8'h02);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
